// File: rtl/hit_logger_1101_if.sv
// rtl/hit_logger_1101_if.sv - hit logger control/status bundle
interface hit_logger_1101_if #(
    parameter int PW = 8,
    parameter int CW = 8
);
    logic          bit_valid;
    logic          hit;
    logic          clr;
    logic          rd_en;
    logic [PW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] hit_count;
    logic          overflow;

    modport master (
        output bit_valid, hit, clr, rd_en,
        input  rd_data, empty, full, hit_count, overflow
    );

    modport slave (
        input  bit_valid, hit, clr, rd_en,
        output rd_data, empty, full, hit_count, overflow
    );
endinterface

// File: rtl/hit_logger_1101.sv
// rtl/hit_logger_1101.sv - logs bit positions of 1101 detector hits into a FIFO
module hit_logger_1101 #(
    parameter int DEPTH = 4,
    parameter int PW    = 8,
    parameter int CW    = 8
) (
    input logic              clk,
    input logic              rst,
    hit_logger_1101_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0] pos;
    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] hit_count_r;
    logic          overflow_r;

    logic empty_w;
    logic full_w;
    logic hit_ev;
    logic push;
    logic pop;
    logic drop;

    assign empty_w = (count == '0);
    assign full_w  = (count == (AW+1)'(DEPTH));
    assign hit_ev  = bus.bit_valid & bus.hit;
    // A pop on an empty FIFO is ignored, so push+pop on empty is a plain push.
    assign pop     = bus.rd_en & ~empty_w;
    assign push    = hit_ev & (~full_w | bus.rd_en);
    assign drop    = hit_ev & full_w & ~bus.rd_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            hit_count_r <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (bus.bit_valid)
                pos <= pos + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Clear wins over a same-cycle hit; dropped hits still count.
            if (bus.clr)
                hit_count_r <= '0;
            else if (hit_ev && hit_count_r != '1)
                hit_count_r <= hit_count_r + 1'b1;
            if (bus.clr)
                overflow_r <= 1'b0;
            else if (drop)
                overflow_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pos;
    end

    assign bus.rd_data   = mem[rd_ptr];
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.hit_count = hit_count_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_hit_logger_1101.sv
// tb/tb_hit_logger_1101.sv - directed scoreboard bench for hit_logger_1101
module tb_hit_logger_1101;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    hit_logger_1101_if #(.PW(8), .CW(8)) bus ();

    hit_logger_1101 #(.DEPTH(4), .PW(8), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic [7:0] m_pos;
    logic [7:0] m_hc;
    logic       m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(bus.full), 32'(q.size() == 4));
        check({tag, ".hit_count"}, 32'(bus.hit_count), 32'(m_hc));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ov));
    endtask

    // One clock: drive at negedge, compare popped head, update model, check after edge.
    task automatic step(input logic bv, input logic h, input logic c, input logic r, input string tag);
        logic       hev;
        logic       was_full;
        logic [7:0] exp;
        @(negedge clk);
        bus.bit_valid = bv;
        bus.hit       = h;
        bus.clr       = c;
        bus.rd_en     = r;
        hev      = bv & h;
        was_full = (q.size() == 4);
        if (r && q.size() > 0) begin
            exp = q.pop_front();
            check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(exp));
        end
        if (hev && (!was_full || r))
            q.push_back(m_pos);
        if (c)
            m_ov = 1'b0;
        else if (hev && was_full && !r)
            m_ov = 1'b1;
        if (c)
            m_hc = 8'd0;
        else if (hev && m_hc != 8'hff)
            m_hc = m_hc + 8'd1;
        if (bv)
            m_pos = m_pos + 8'd1;
        @(posedge clk);
        #1;
        check_flags(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst           = 1'b0;
        bus.bit_valid = 1'b1;
        bus.hit       = 1'b1;
        bus.clr       = 1'b0;
        bus.rd_en     = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_pos = 8'd0;
        m_hc  = 8'd0;
        m_ov  = 1'b0;
        check_flags(tag);
        @(negedge clk);
        rst           = 1'b1;
        bus.bit_valid = 1'b0;
        bus.hit       = 1'b0;
    endtask

    logic [6:0] stream;
    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b1;
        bus.bit_valid = 1'b0;
        bus.hit = 1'b0;
        bus.clr = 1'b0;
        bus.rd_en = 1'b0;
        do_reset("reset0");

        // Serial 1,1,0,1,1,0,1: 1101 completes at bit indices 3 and 6.
        stream = 7'b1011011;
        for (int i = 0; i < 7; i++)
            step(1'b1, (i == 3 || i == 6), 1'b0, 1'b0, "stream");
        check("stream.head", 32'(bus.rd_data), 32'd3);
        check("stream.hc", 32'(bus.hit_count), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, "stream.pop1");
        step(1'b0, 1'b0, 1'b0, 1'b1, "stream.pop2");

        // Five hits, no reads: fifth dropped.
        do_reset("reset1");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, "fill5");
        check("fill5.ov", 32'(bus.overflow), 32'd1);
        check("fill5.hc", 32'(bus.hit_count), 32'd5);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, "drain4");

        // Clear with simultaneous dropped hit, then full + hit + rd_en.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, "refill");
        step(1'b1, 1'b1, 1'b0, 1'b0, "drop");
        step(1'b1, 1'b1, 1'b1, 1'b0, "clr_drop");
        check("clr_drop.ov", 32'(bus.overflow), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, "full_pushpop");
        check("full_pushpop.full", 32'(bus.full), 32'd1);
        check("full_pushpop.ov", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, "drain_b");

        // Unqualified hit and pop on empty.
        step(1'b0, 1'b1, 1'b0, 1'b0, "hit_nobv");
        step(1'b0, 1'b0, 1'b0, 1'b1, "pop_empty");
        step(1'b1, 1'b1, 1'b0, 1'b1, "pushpop_empty");
        step(1'b0, 1'b0, 1'b0, 1'b1, "pop_after");

        // Position wrap after 256 bits, then saturation of hit_count.
        do_reset("reset2");
        for (int i = 0; i < 256; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, "wrap_run");
        step(1'b1, 1'b1, 1'b0, 1'b0, "wrap_hit");
        check("wrap.head", 32'(bus.rd_data), 32'd0);
        for (int i = 0; i < 260; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, "sat");
        check("sat.hc", 32'(bus.hit_count), 32'd255);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, "sat_drain");

        // Reset mid-operation discards entries.
        step(1'b1, 1'b1, 1'b0, 1'b0, "pre_rst1");
        step(1'b1, 1'b1, 1'b0, 1'b0, "pre_rst2");
        do_reset("reset3");
        check("reset3.empty", 32'(bus.empty), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "post_rst");
        check("post_rst.head", 32'(bus.rd_data), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, "post_rst_pop");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
